serial_subtractor: RTL
======================

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits (legal: WIDTH >= 2).
REQ-002 SHALL have parameter DIGIT, default 1, bits processed per cycle (legal: DIGIT >= 1 and WIDTH % DIGIT == 0); N = WIDTH/DIGIT.
REQ-003 SHALL have one clock; reset is synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 in_valid  input  1  operand request valid.
REQ-007 in_ready  output  1  block can accept operands.
REQ-008 a  input  WIDTH  minuend.
REQ-009 b  input  WIDTH  subtrahend.
REQ-010 bin  input  1  borrow-in to LSB.
REQ-011 signed_mode  input  1  1 = two's-complement overflow rule, 0 = unsigned rule; sampled with operands.
REQ-012 out_valid  output  1  result valid.
REQ-013 out_ready  input  1  consumer accepts result.
REQ-014 diff  output  WIDTH  a - b - bin, modulo 2^WIDTH.
REQ-015 bout  output  1  borrow-out of MSB.
REQ-016 ovf  output  1  overflow flag per mode latched at accept.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DONE.
REQ-019 IDLE: in_ready=1, out_valid=0; on in_valid=1 (accept) SHALL latch a, b, signed_mode, load borrow register with bin, clear digit counter, go to RUN.
REQ-020 RUN: in_ready=0; each cycle SHALL subtract DIGIT bits LSB-first via ripple of full-subtractor cells (d = x^y^br; br_out = (~x&y) | (~(x^y)&br)), write digit into diff register, update borrow register, increment counter.
REQ-021 After the N-th RUN cycle SHALL go to DONE; handshake-to-out_valid latency is exactly N+1 clocks (accept edge + N RUN edges).
REQ-022 DONE: out_valid=1, diff/bout/ovf stable; on out_ready=1 SHALL return to IDLE the next edge; with out_ready=0, SHALL hold all outputs indefinitely.
REQ-023 in_ready SHALL be 1 only in IDLE; no accept in DONE, even if out_ready=1 the same cycle (one idle cycle between jobs).
REQ-024 in_valid and a/b/bin/signed_mode SHALL be ignored outside IDLE.
REQ-025 bout SHALL equal borrow out of bit WIDTH-1.
REQ-026 signed_mode=0: ovf SHALL equal bout.
REQ-027 signed_mode=1: ovf SHALL equal borrow into bit WIDTH-1 XOR borrow out of bit WIDTH-1.
REQ-028 When DIGIT=WIDTH, N=1: a single RUN cycle SHALL compute the full result; latency 2.
REQ-029 diff, bout, ovf SHALL only change during RUN, or at reset; values are don't-care-free (registered) at all times.
REQ-030 Counter width SHALL be sufficient for N without wrap before DONE.

Reset
REQ-031 rst_n=0 at a rising edge SHALL force IDLE, counter=0, borrow=0, diff=0, bout=0, ovf=0, out_valid=0, busy=0, in_ready=1 on the following cycle.
REQ-032 Reset asserted in RUN or DONE SHALL abort the job with no result produced; first accept allowed the cycle after rst_n returns high.
REQ-033 Reset SHALL take priority over every handshake event in the same cycle.

Verification (WIDTH=8, DIGIT=1 unless stated)
REQ-034 a=0x05, b=0x03, bin=0, unsigned -> after 9 clocks out_valid=1, diff=0x02, bout=0, ovf=0.
REQ-035 a=0x00, b=0x01, bin=0: unsigned -> diff=0xFF, bout=1, ovf=1; signed -> diff=0xFF, bout=1, ovf=0.
REQ-036 a=0x80, b=0x01, bin=0, signed -> diff=0x7F, bout=0, ovf=1; a=0x80, b=0x00, bin=1 signed -> diff=0x7F, ovf=1.
REQ-037 Hold out_ready=0 for 20 cycles in DONE -> outputs constant, in_ready=0, new in_valid pulses ignored; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 rst_n=0 at RUN cycle 4 -> next cycle IDLE, all outputs zero, no out_valid; subsequent 0x10-0x01 -> diff=0x0F.
REQ-039 WIDTH=8, DIGIT=4: a=0x3C, b=0x4D, bin=1 unsigned -> out_valid 3 clocks after accept, diff=0xEE, bout=1, ovf=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// rtl/serial_subtractor.sv - digit-serial a - b - bin subtractor with valid/ready handshakes
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  input  logic             signed_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf,
  output logic             busy
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               signed_q, signed_d;
  logic               br_q, br_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   diff_q, diff_d;
  logic               bout_q, bout_d;
  logic               ovf_q, ovf_d;

  // Digit datapath: ripple of full-subtractor cells over the low DIGIT bits
  // of the operand shift registers; also exposes the borrow entering the
  // top cell, which becomes the borrow into bit WIDTH-1 on the last digit.
  logic [DIGIT-1:0]       dig;
  logic                   br_c;
  logic                   br_msb_in;
  logic [WIDTH+DIGIT-1:0] diff_sh;

  // Ripple the borrow through one digit
  always_comb begin
    dig       = '0;
    br_c      = br_q;
    br_msb_in = br_q;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) br_msb_in = br_c;
      dig[i] = a_q[i] ^ b_q[i] ^ br_c;
      br_c   = (~a_q[i] & b_q[i]) | (~(a_q[i] ^ b_q[i]) & br_c);
    end
  end

  // Next-state and datapath updates; result registers move only in RUN
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    signed_d = signed_q;
    br_d     = br_q;
    cnt_d    = cnt_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    diff_sh  = {dig, diff_q};
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = b;
          signed_d = signed_mode;
          br_d     = bin;
          cnt_d    = '0;
          state_d  = RUN;
        end
      end
      RUN: begin
        // Digits enter at the top and shift down, so after N steps the
        // first (least significant) digit sits at bit 0.
        diff_d = diff_sh[WIDTH+DIGIT-1:DIGIT];
        a_d    = a_q >> DIGIT;
        b_d    = b_q >> DIGIT;
        br_d   = br_c;
        cnt_d  = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(N - 1)) begin
          bout_d  = br_c;
          ovf_d   = signed_q ? (br_msb_in ^ br_c) : br_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      signed_q <= 1'b0;
      br_q     <= 1'b0;
      cnt_q    <= '0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      signed_q <= signed_d;
      br_q     <= br_d;
      cnt_q    <= cnt_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign diff      = diff_q;
  assign bout      = bout_q;
  assign ovf       = ovf_q;

endmodule
